// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 7;
    localparam int RD_LSB   = 7;
    localparam int F3_LSB   = 12;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int F7B5_POS = 30;
    localparam int REG_W    = 5;

    typedef enum logic [1:0] {
        S_FETCH,
        S_BUFFERED,
        S_DISCARD
    } state_e;

    function automatic logic [XLEN-1:0] align4(
        input logic [XLEN-1:0] a
    );
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register; flush beats load, otherwise holds.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, one-entry skid buffer, redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_unit_if.master         imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    output logic                 id_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [ILEN-1:0]      id_instr,
    output logic [OPC_W-1:0]     Opcode,
    output logic [3:0]           Func,
    output logic [REG_W-1:0]     rd,
    output logic [REG_W-1:0]     rs1,
    output logic [REG_W-1:0]     rs2
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] stale_q, stale_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [ILEN-1:0] skid_instr_q, skid_instr_d;

    logic            id_load;
    logic            id_flush;
    logic [XLEN-1:0] id_pc_in;
    logic [ILEN-1:0] id_instr_in;
    logic            id_free;

    assign id_free = !id_valid || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        id_load      = 1'b0;
        id_flush     = 1'b0;
        id_pc_in     = pc_q;
        id_instr_in  = imem.imem_rdata;
        if (branch_taken) begin
            pc_d         = align4(branch_target);
            id_flush     = 1'b1;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            unique case (state_q)
                S_FETCH: begin
                    // An outstanding request must drain before the target.
                    if (!imem.imem_valid) begin
                        state_d = S_DISCARD;
                        stale_d = pc_q;
                    end
                end
                S_BUFFERED: state_d = S_FETCH;
                S_DISCARD:  state_d = S_DISCARD;
                default:    state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        pc_d = pc_q + XLEN'(4);
                        if (id_free) begin
                            id_load = 1'b1;
                        end else begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem.imem_rdata;
                            state_d      = S_BUFFERED;
                        end
                    end else if (!stall) begin
                        id_flush = 1'b1;
                    end
                end
                S_BUFFERED: begin
                    if (!stall) begin
                        id_load     = 1'b1;
                        id_pc_in    = skid_pc_q;
                        id_instr_in = skid_instr_q;
                        state_d     = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    id_flush = 1'b1;
                    if (imem.imem_valid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            stale_q      <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem.imem_req  = reset_n && (state_q != S_BUFFERED);
    assign imem.imem_addr = (state_q == S_DISCARD) ? stale_q : pc_q;

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (reset_n),
        .load    (id_load),
        .flush   (id_flush),
        .pc_i    (id_pc_in),
        .instr_i (id_instr_in),
        .valid_o (id_valid),
        .pc_o    (id_pc),
        .instr_o (id_instr)
    );

    assign Opcode = id_instr[OPC_LSB +: OPC_W];
    assign Func   = {id_instr[F7B5_POS], id_instr[F3_LSB +: 3]};
    assign rd     = id_instr[RD_LSB +: REG_W];
    assign rs1    = id_instr[RS1_LSB +: REG_W];
    assign rs2    = id_instr[RS2_LSB +: REG_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a program-order model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [63:0] tgt = '0;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  Opcode;
    logic [3:0]  Func;
    logic [4:0]  rd, rs1, rs2;

    int total = 0;
    int bad = 0;
    int lat_mode = 0;
    int lat_r;
    int wcnt;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(64'h80)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem          (bus),
        .stall         (stall),
        .branch_taken  (br),
        .branch_target (tgt),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .Opcode        (Opcode),
        .Func          (Func),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h200) return 32'h40B50533;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0013;
    endfunction

    // Memory model: answers after lat cycles of a held request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt  <= 0;
            lat_r <= 0;
        end else if (bus.imem_req && !bus.imem_valid) begin
            wcnt <= wcnt + 1;
        end else if (bus.imem_req) begin
            wcnt  <= 0;
            lat_r <= int'($urandom_range(0, 2));
        end
    end

    assign bus.imem_rdata = mem_word(bus.imem_addr);
    assign bus.imem_valid = bus.imem_req &&
        (wcnt >= ((lat_mode >= 0) ? lat_mode : lat_r));

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] paddr;
        logic        pend;
        logic        chk_flush;
        int          consumed;
        int          waited;

        tick();
        tick();
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_instr", id_instr, 0);

        reset_n = 1'b1;
        #1;
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 64'h80);
        tick();
        chk("first_valid", id_valid, 1);
        chk("first_pc", id_pc, 64'h80);
        chk("first_instr", id_instr, mem_word(64'h80));

        br = 1'b1;
        tgt = 64'h0;
        tick();
        chk("br0_flush", id_valid, 0);
        br = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", id_valid, 1);
            chk("stream_pc", id_pc, 64'(i * 4));
        end

        br = 1'b1;
        tgt = 64'h200;
        tick();
        br = 1'b0;
        tick();
        chk("sub_pc", id_pc, 64'h200);
        chk("sub_opcode", Opcode, 7'h33);
        chk("sub_func", Func, 4'b1000);
        chk("sub_rd", rd, 10);
        chk("sub_rs1", rs1, 10);
        chk("sub_rs2", rs2, 11);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", bus.imem_req, 0);
            chk("stall_valid", id_valid, 1);
            chk("stall_pc", id_pc, 64'h200);
        end
        stall = 1'b0;
        tick();
        chk("skid_pc", id_pc, 64'h204);
        chk("skid_instr", id_instr, mem_word(64'h204));
        tick();
        chk("after_skid_pc", id_pc, 64'h208);

        lat_mode = 2;
        tick();
        br = 1'b1;
        tgt = 64'h103;
        tick();
        br = 1'b0;
        chk("disc_req", bus.imem_req, 1);
        chk("disc_addr", bus.imem_addr, 64'h20C);
        chk("disc_valid", id_valid, 0);
        tick();
        chk("redir_addr", bus.imem_addr, 64'h100);
        chk("redir_valid", id_valid, 0);
        waited = 0;
        while (!id_valid && waited < 10) begin
            tick();
            waited++;
        end
        chk("redir_arrive", id_valid, 1);
        chk("redir_pc", id_pc, 64'h100);
        chk("redir_instr", id_instr, mem_word(64'h100));

        lat_mode = 0;
        stall = 1'b1;
        br = 1'b1;
        tgt = 64'h300;
        tick();
        chk("br_stall_flush", id_valid, 0);
        stall = 1'b0;
        br = 1'b0;
        tick();
        chk("br_stall_pc", id_pc, 64'h300);

        br = 1'b1;
        tgt = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        br = 1'b0;
        tick();
        chk("wrap_top", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_zero", id_pc, 64'h0);

        lat_mode = 2;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.imem_req, 0);
        chk("mid_rst_valid", id_valid, 0);
        chk("mid_rst_pc", id_pc, 0);
        chk("mid_rst_instr", id_instr, 0);
        tick();
        lat_mode = 0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_addr", bus.imem_addr, 64'h80);
        tick();
        chk("post_rst_pc", id_pc, 64'h80);

        lat_mode = -1;
        exp_pc = 64'h80;
        pend = 1'b0;
        paddr = '0;
        chk_flush = 1'b0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (chk_flush) chk("rnd_flush", id_valid, 0);
            if (pend && bus.imem_req)
                chk("rnd_addr_hold", bus.imem_addr, paddr);
            stall = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 19) == 0);
            tgt = {$urandom, $urandom};
            #1;
            if (id_valid && !stall && !br) begin
                chk("rnd_pc", id_pc, exp_pc);
                chk("rnd_instr", id_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            if (br) exp_pc = tgt & ~64'h3;
            chk_flush = br;
            pend = bus.imem_req && !bus.imem_valid;
            paddr = bus.imem_addr;
            tick();
        end
        chk("rnd_progress", 64'(consumed > 300), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
